// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions for the padder and the compression core.
//   pad_state_t : padder FSM states
//   BLOCK_BYTES : bytes per 512-bit block
//   LEN_POS     : first byte of the 64-bit big-endian length field
//   PAD_BYTE    : the mandatory 1-bit marker byte that follows the message
//   K, H_INIT   : round constants and initial hash value used by the core
package sha256_pkg;

    typedef enum logic [2:0] {
        FILL,
        PAD,
        EMIT_MID,
        EMIT_LAST,
        EXTRA
    } pad_state_t;

    localparam int         BLOCK_BYTES = 64;
    localparam int         LEN_POS     = 56;
    localparam logic [7:0] PAD_BYTE    = 8'h80;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] H_INIT [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

endpackage

// File: rtl/sha256_padder.sv
// SHA-256 message padder: collects a byte stream into 512-bit blocks, appends
// the 0x80 marker, zero fill and the 64-bit big-endian bit length, and hands
// complete blocks to the compression core.
// Ports:
//   clock, reset          : clock, asynchronous active-low reset
//   in_valid/in_ready     : byte beat handshake
//   in_data, in_last      : message byte, final beat of message
//   in_empty              : beat carries no byte (only meaningful with in_last)
//   out_valid/out_ready   : block handshake towards the core
//   out_block             : 512-bit block, byte 0 in [511:504]
//   out_first, out_last   : first / final block of the current message
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_CNT_W = 61
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    input  logic         in_empty,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] out_block,
    output logic         out_first,
    output logic         out_last
);

    pad_state_t           state;
    logic [511:0]         blk;
    logic [6:0]           byte_idx;   // 0..64; doubles as the pad position p in PAD
    logic [LEN_CNT_W-1:0] cnt;
    logic [63:0]          len_q;
    logic                 first_flag;
    logic                 next_is_extra;
    logic                 extra_lead80;

    logic                 beat;
    logic                 blk_xfer;
    logic [LEN_CNT_W-1:0] cnt_nxt;
    logic [6:0]           idx_nxt;

    // Overlays the marker byte at p, zeros after it and, when the length fits
    // in this block (p <= 55), the bit length in bytes 56..63. p == 64 leaves
    // the block untouched; the marker then goes into the extra block.
    function automatic logic [511:0] pad_block(input logic [511:0] b,
                                               input logic [6:0]   p,
                                               input logic [63:0]  len);
        logic [511:0] r;
        r = b;
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (i == int'(p)) begin
                r[511-8*i -: 8] = PAD_BYTE;
            end else if (i > int'(p)) begin
                if (int'(p) < LEN_POS && i >= LEN_POS)
                    r[511-8*i -: 8] = len[8*(BLOCK_BYTES-1-i) +: 8];
                else
                    r[511-8*i -: 8] = 8'h00;
            end
        end
        return r;
    endfunction

    assign beat      = in_valid & in_ready;
    assign blk_xfer  = out_valid & out_ready;
    assign out_block = blk;

    always_comb begin
        cnt_nxt = cnt;
        idx_nxt = byte_idx;
        if (!in_empty) begin
            cnt_nxt = cnt + LEN_CNT_W'(1);
            idx_nxt = byte_idx + 7'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= FILL;
            blk           <= '0;
            byte_idx      <= '0;
            cnt           <= '0;
            len_q         <= '0;
            first_flag    <= 1'b1;
            next_is_extra <= 1'b0;
            extra_lead80  <= 1'b0;
            in_ready      <= 1'b0;
            out_valid     <= 1'b0;
            out_first     <= 1'b0;
            out_last      <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    in_ready <= 1'b1;
                    if (beat) begin
                        if (!in_empty)
                            blk[511 - 8*int'(byte_idx[5:0]) -: 8] <= in_data;
                        byte_idx <= idx_nxt;
                        cnt      <= cnt_nxt;
                        if (in_last) begin
                            // Length is frozen here so the next message cannot disturb it.
                            len_q    <= 64'({cnt_nxt, 3'b000});
                            state    <= PAD;
                            in_ready <= 1'b0;
                        end else if (!in_empty && byte_idx == 7'(BLOCK_BYTES - 1)) begin
                            next_is_extra <= 1'b0;
                            state         <= EMIT_MID;
                            in_ready      <= 1'b0;
                            out_valid     <= 1'b1;
                            out_first     <= first_flag;
                            out_last      <= 1'b0;
                        end
                    end
                end

                PAD: begin
                    blk       <= pad_block(blk, byte_idx, len_q);
                    out_valid <= 1'b1;
                    out_first <= first_flag;
                    if (int'(byte_idx) < LEN_POS) begin
                        state    <= EMIT_LAST;
                        out_last <= 1'b1;
                    end else begin
                        next_is_extra <= 1'b1;
                        extra_lead80  <= (int'(byte_idx) == BLOCK_BYTES);
                        state         <= EMIT_MID;
                        out_last      <= 1'b0;
                    end
                end

                EMIT_MID: begin
                    if (blk_xfer) begin
                        first_flag <= 1'b0;
                        out_valid  <= 1'b0;
                        out_first  <= 1'b0;
                        if (next_is_extra) begin
                            state <= EXTRA;
                        end else begin
                            state    <= FILL;
                            byte_idx <= '0;
                            in_ready <= 1'b1;
                        end
                    end
                end

                EXTRA: begin
                    blk       <= {(extra_lead80 ? PAD_BYTE : 8'h00), 440'd0, len_q};
                    state     <= EMIT_LAST;
                    out_valid <= 1'b1;
                    out_first <= first_flag;
                    out_last  <= 1'b1;
                end

                EMIT_LAST: begin
                    if (blk_xfer) begin
                        state      <= FILL;
                        byte_idx   <= '0;
                        cnt        <= '0;
                        first_flag <= 1'b1;
                        out_valid  <= 1'b0;
                        out_first  <= 1'b0;
                        out_last   <= 1'b0;
                        in_ready   <= 1'b1;
                    end
                end

                default: begin
                    state    <= FILL;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
